// File: rtl/dram_pkg.sv
// dram_pkg: shared FSM state type, default age width and parameter-legality check macro.
package dram_pkg;
  typedef enum logic [1:0] {IDLE, REF_ACT, REF_PRE} state_e;
  localparam int RETENTION_DEF = 100;
  localparam int AGE_W = $clog2(RETENTION_DEF + 1);
endpackage

`define DRAM_PARAM_CHECK(lbl, cond) if (!(cond)) begin : lbl $error("dram_refresh_ctrl: illegal parameter combination"); end

// File: rtl/dram_row_timer.sv
// dram_row_timer: per-row saturating retention age with valid flag; write restores, refresh only resets age.
module dram_row_timer #(
  parameter int RETENTION = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic wr_i,
  output logic valid_o,
  output logic expire_o
);
  localparam int AW = $clog2(RETENTION + 1);
  logic [AW-1:0] age_q, age_d;
  logic valid_q, valid_d;
  always_comb begin
    expire_o = !wr_i && !clr_i && age_q == AW'(RETENTION - 1);
    age_d = (wr_i || clr_i) ? '0 : (age_q == AW'(RETENTION) ? age_q : age_q + 1'b1);
    valid_d = wr_i ? 1'b1 : (expire_o ? 1'b0 : valid_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '0;
      valid_q <= 1'b1;
    end else begin
      age_q <= age_d;
      valid_q <= valid_d;
    end
  end
  assign valid_o = valid_q;
endmodule

// File: rtl/dram_refresh_ctrl.sv
// dram_refresh_ctrl: DRAM row array with retention decay, round-robin auto refresh,
// manual refresh and a ready/rvalid host port.
module dram_refresh_ctrl
  import dram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int REFRESH_INTERVAL = 8,
  parameter int RETENTION = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              auto_en_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              refresh_i,
  input  logic [ADDR_W-1:0] refresh_addr_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] dout_o,
  output logic              refresh_busy_o,
  output logic              decay_err_o
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW = $clog2(REFRESH_INTERVAL);
  `DRAM_PARAM_CHECK(g_bad_interval, REFRESH_INTERVAL >= 4)
  `DRAM_PARAM_CHECK(g_bad_retention, RETENTION > REFRESH_INTERVAL * DEPTH)
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ref_row_q, ref_row_d;
  logic ref_auto_q, ref_auto_d, pend_q, pend_d;
  logic rvalid_q, rvalid_d, derr_q, derr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DEPTH-1:0] valid, expire;
  logic wrap, idle, start_auto, start_man, wr, rd;
  always_comb begin
    idle = state_q == IDLE;
    wrap = auto_en_i && cnt_q == CW'(REFRESH_INTERVAL - 1);
    cnt_d = auto_en_i ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
    ready_o = idle && !pend_q && !refresh_i;
    wr = req_i && ready_o && we_i;
    rd = req_i && ready_o && !we_i;
    start_auto = idle && pend_q;
    start_man = idle && !pend_q && refresh_i;
    state_d = state_q == REF_ACT ? REF_PRE : state_q == REF_PRE ? IDLE :
              (pend_q || refresh_i) ? REF_ACT : IDLE;
    ref_row_d = start_auto ? ptr_q : start_man ? refresh_addr_i : ref_row_q;
    ref_auto_d = idle ? pend_q : ref_auto_q;
    ptr_d = (state_q == REF_PRE && ref_auto_q) ? ptr_q + 1'b1 : ptr_q;
    // a wrap landing on the entry cycle re-arms rather than being lost
    pend_d = wrap || (pend_q && !start_auto);
    rvalid_d = rd;
    derr_d = rd && !valid[addr_i];
    dout_d = rd ? (valid[addr_i] ? mem_q[addr_i] : '0) : dout_q;
    for (int i = 0; i < DEPTH; i++)
      mem_d[i] = (wr && addr_i == ADDR_W'(i)) ? din_i : (expire[i] ? '0 : mem_q[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
      ptr_q <= '0;
      ref_row_q <= '0;
      ref_auto_q <= 1'b0;
      pend_q <= 1'b0;
      rvalid_q <= 1'b0;
      derr_q <= 1'b0;
      dout_q <= '0;
    end else begin
      mem_q <= mem_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      ref_row_q <= ref_row_d;
      ref_auto_q <= ref_auto_d;
      pend_q <= pend_d;
      rvalid_q <= rvalid_d;
      derr_q <= derr_d;
      dout_q <= dout_d;
    end
  end
  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    dram_row_timer #(.RETENTION(RETENTION)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (state_q == REF_ACT && ref_row_q == ADDR_W'(r)),
      .wr_i     (wr && addr_i == ADDR_W'(r)),
      .valid_o  (valid[r]),
      .expire_o (expire[r])
    );
  end
  assign rvalid_o = rvalid_q;
  assign dout_o = dout_q;
  assign decay_err_o = derr_q;
  assign refresh_busy_o = !idle;
endmodule
